// File: rtl/conv_layer_input_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_layer_input_ctrl_pkg
// Shared definitions for the conv-layer input controller and the input cache:
//   - state_t : layer FSM states (encodings 0..7, driven out as current_state)
//   - cmd_t   : sequencer -> controller command codes
//   - ack_t   : controller -> sequencer acknowledge codes
//   - DATA_WIDTH, FLOAT32_ONE : pixel word width and the float32 constant 1.0
//   - bank_select() : cache row-bank selection for a given FSM state
// -----------------------------------------------------------------------------
package conv_layer_input_ctrl_pkg;

  localparam int          DATA_WIDTH  = 32;
  localparam logic [31:0] FLOAT32_ONE = 32'h3F80_0000;

  typedef enum logic [2:0] {
    STATE_INIT    = 3'd0,
    STATE_PRELOAD = 3'd1,
    STATE_ROW_0   = 3'd2,
    STATE_ROW_1   = 3'd3,
    STATE_ROW_2   = 3'd4,
    STATE_BIAS    = 3'd5,
    STATE_LOAD    = 3'd6,
    STATE_IDLE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CMD_IDLE          = 2'd0,
    CMD_PRELOAD_START = 2'd1,
    CMD_SHIFT_START   = 2'd2,
    CMD_LOAD_START    = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ACK_IDLE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_t;

  // Bank the cache should steer to while in state s. During PRELOAD each
  // image row lands in its own bank; LOAD refills the last bank.
  function automatic logic [1:0] bank_select(input state_t     s,
                                             input logic [1:0] preload_cycle,
                                             input logic [1:0] last_bank);
    logic [1:0] bank;
    bank = 2'd0;
    case (s)
      STATE_PRELOAD: bank = preload_cycle;
      STATE_ROW_1:   bank = 2'd1;
      STATE_ROW_2:   bank = 2'd2;
      STATE_LOAD:    bank = last_bank;
      default:       bank = 2'd0;
    endcase
    return bank;
  endfunction

endpackage

// File: rtl/conv_layer_input_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_layer_input_addr_gen
// Holds the image row pointer and forms the ROM address of the next fetch.
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_row_clr          : clear the row pointer (takes priority over increment)
//   i_row_inc          : advance the row pointer by one
//   i_col              : column index of the next fetch
//   o_row_ptr          : registered row pointer
//   o_row_ptr_next     : row pointer value after this edge
//   o_rom_addr         : BASE_ADDR + row_next*IMAGE_SIZE + col, truncated
// -----------------------------------------------------------------------------
module conv_layer_input_addr_gen #(
  parameter int IMAGE_SIZE = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int ROW_W      = $clog2(IMAGE_SIZE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_row_clr,
  input  logic                  i_row_inc,
  input  logic [4:0]            i_col,
  output logic [ROW_W-1:0]      o_row_ptr,
  output logic [ROW_W-1:0]      o_row_ptr_next,
  output logic [ADDR_WIDTH-1:0] o_rom_addr
);

  logic [ROW_W-1:0] r_row_ptr;
  logic [ROW_W-1:0] w_row_ptr_next;

  always_comb begin
    w_row_ptr_next = r_row_ptr;
    if (i_row_clr) begin
      w_row_ptr_next = '0;
    end else if (i_row_inc) begin
      w_row_ptr_next = r_row_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_row_ptr <= '0;
    end else begin
      r_row_ptr <= w_row_ptr_next;
    end
  end

  // The ROM has one cycle of read latency, so the address is built from the
  // values that will be current when the data comes back.
  assign o_rom_addr = ADDR_WIDTH'(BASE_ADDR + 32'(w_row_ptr_next) * IMAGE_SIZE
                                  + 32'(i_col));

  assign o_row_ptr      = r_row_ptr;
  assign o_row_ptr_next = w_row_ptr_next;

endmodule

// File: rtl/conv_layer_input_ctrl.sv
// -----------------------------------------------------------------------------
// conv_layer_input_ctrl
// Layer FSM and address generation in front of the conv-layer input cache.
// Fetches image rows from a synchronous ROM and steers the cache row banks.
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_cmd              : sequencer command (cmd_t)
//   o_ack              : one-cycle acknowledge pulse (ack_t)
//   o_rom_addr         : ROM address, combinational from next-state logic
//   i_rom_data         : ROM read data (one cycle after the address)
//   o_data_out         : pixel to the cache (pass-through of i_rom_data)
//   o_current_state    : FSM state (state_t)
//   o_read_index       : word index within the current phase
//   o_preload_cycle    : preload row counter 0..2
//   o_array_idx        : cache bank select 0..2
//   o_image_done       : all image rows have been fetched
// -----------------------------------------------------------------------------
module conv_layer_input_ctrl
  import conv_layer_input_ctrl_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int ARRAY_SIZE  = 6,
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_cmd,
  output logic [1:0]            o_ack,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic [2:0]            o_current_state,
  output logic [4:0]            o_read_index,
  output logic [1:0]            o_preload_cycle,
  output logic [1:0]            o_array_idx,
  output logic                  o_image_done
);

  localparam int         ROW_W     = $clog2(IMAGE_SIZE + 1);
  localparam logic [4:0] LAST_COL  = 5'(IMAGE_SIZE - 1);
  localparam logic [4:0] SHIFT_COL = 5'(IMAGE_SIZE);
  localparam logic [4:0] LAST_K    = 5'(KERNEL_SIZE - 1);
  localparam logic [1:0] LAST_BANK = 2'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(IMAGE_SIZE);

  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_array_size_check
    $error("ARRAY_SIZE must equal IMAGE_SIZE - KERNEL_SIZE + 1");
  end

  state_t     r_state, w_state_next;
  logic [4:0] r_read_index, w_read_index_next;
  logic [1:0] r_preload_cycle, w_preload_cycle_next;
  logic [1:0] r_array_idx, w_array_idx_next;
  ack_t       r_ack, w_ack_next;
  logic       r_image_done, w_image_done_next;
  // Set when INIT was entered from IDLE: that INIT lasts one cycle and
  // advances to PRELOAD without waiting for another command.
  logic       r_restart, w_restart_next;

  logic             w_row_clr;
  logic             w_row_inc;
  logic [ROW_W-1:0] w_row_ptr;
  logic [ROW_W-1:0] w_row_ptr_next;

  conv_layer_input_addr_gen #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .ROW_W      (ROW_W)
  ) u_addr_gen (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_row_clr      (w_row_clr),
    .i_row_inc      (w_row_inc),
    .i_col          (w_read_index_next),
    .o_row_ptr      (w_row_ptr),
    .o_row_ptr_next (w_row_ptr_next),
    .o_rom_addr     (o_rom_addr)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= STATE_INIT;
      r_read_index    <= '0;
      r_preload_cycle <= '0;
      r_array_idx     <= '0;
      r_ack           <= ACK_IDLE;
      r_image_done    <= 1'b0;
      r_restart       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_read_index    <= w_read_index_next;
      r_preload_cycle <= w_preload_cycle_next;
      r_array_idx     <= w_array_idx_next;
      r_ack           <= w_ack_next;
      r_image_done    <= w_image_done_next;
      r_restart       <= w_restart_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next         = r_state;
    w_read_index_next    = r_read_index;
    w_preload_cycle_next = r_preload_cycle;
    w_restart_next       = 1'b0;
    w_row_clr            = 1'b0;
    w_row_inc            = 1'b0;
    case (r_state)
      STATE_INIT: begin
        w_read_index_next = '0;
        if (r_restart || cmd_t'(i_cmd) == CMD_PRELOAD_START) begin
          w_state_next         = STATE_PRELOAD;
          w_preload_cycle_next = '0;
          w_row_clr            = 1'b1;
        end
      end
      STATE_IDLE: begin
        w_read_index_next = '0;
        case (cmd_t'(i_cmd))
          CMD_PRELOAD_START: begin
            w_state_next   = STATE_INIT;
            w_restart_next = 1'b1;
            w_row_clr      = 1'b1;
          end
          CMD_SHIFT_START: w_state_next = STATE_ROW_0;
          CMD_LOAD_START: begin
            if (w_row_ptr < ROW_LIMIT) begin
              w_state_next = STATE_LOAD;
            end
          end
          default: ;
        endcase
      end
      STATE_PRELOAD: begin
        // The last preload row skips the shift slot so it stays in its bank.
        if (r_preload_cycle == LAST_BANK && r_read_index == LAST_COL) begin
          w_state_next      = STATE_IDLE;
          w_read_index_next = '0;
          w_row_inc         = 1'b1;
        end else if (r_read_index == SHIFT_COL) begin
          w_read_index_next    = '0;
          w_preload_cycle_next = r_preload_cycle + 2'd1;
          w_row_inc            = 1'b1;
        end else begin
          w_read_index_next = r_read_index + 5'd1;
        end
      end
      STATE_ROW_0, STATE_ROW_1, STATE_ROW_2: begin
        if (r_read_index == LAST_K) begin
          w_read_index_next = '0;
          if (r_state == STATE_ROW_0) begin
            w_state_next = STATE_ROW_1;
          end else if (r_state == STATE_ROW_1) begin
            w_state_next = STATE_ROW_2;
          end else begin
            w_state_next = STATE_BIAS;
          end
        end else begin
          w_read_index_next = r_read_index + 5'd1;
        end
      end
      STATE_BIAS: begin
        w_state_next      = STATE_IDLE;
        w_read_index_next = '0;
      end
      STATE_LOAD: begin
        if (r_read_index == LAST_COL) begin
          w_state_next      = STATE_IDLE;
          w_read_index_next = '0;
          w_row_inc         = 1'b1;
        end else begin
          w_read_index_next = r_read_index + 5'd1;
        end
      end
      default: begin
        w_state_next      = STATE_INIT;
        w_read_index_next = '0;
      end
    endcase
    // Hold the ROM address at BASE_ADDR while reset is asserted.
    if (!i_rst_n) begin
      w_row_clr         = 1'b1;
      w_row_inc         = 1'b0;
      w_read_index_next = '0;
    end
  end

  // Output logic: values the registered outputs take after this edge
  always_comb begin
    w_array_idx_next = bank_select(w_state_next, w_preload_cycle_next, LAST_BANK);
    w_ack_next       = ACK_IDLE;
    if (r_state == STATE_IDLE) begin
      // A LOAD with no rows left is answered at once without a fetch.
      if (cmd_t'(i_cmd) == CMD_LOAD_START && w_row_ptr >= ROW_LIMIT) begin
        w_ack_next = ACK_LOAD_FIN;
      end
    end else if (w_state_next == STATE_IDLE) begin
      case (r_state)
        STATE_PRELOAD: w_ack_next = ACK_PRELOAD_FIN;
        STATE_BIAS:    w_ack_next = ACK_SHIFT_FIN;
        STATE_LOAD:    w_ack_next = ACK_LOAD_FIN;
        default:       w_ack_next = ACK_IDLE;
      endcase
    end
    w_image_done_next = (w_row_ptr_next >= ROW_LIMIT);
  end

  assign o_ack           = r_ack;
  assign o_current_state = r_state;
  assign o_read_index    = r_read_index;
  assign o_preload_cycle = r_preload_cycle;
  assign o_array_idx     = r_array_idx;
  assign o_image_done    = r_image_done;
  assign o_data_out      = i_rom_data;

endmodule

// File: doc/conv_layer_input_ctrl.md
Name: conv_layer_input_ctrl

Overview:
- Control and address-generation stage that sits directly upstream of the conv-layer input cache.
- Runs the layer FSM and produces current_state, read_index, preload_cycle and array_idx, which steer the cache's three row banks.
- Fetches image pixels row by row from the synchronous input ROM and forwards them as the cache's data_in.
- Answers the layer sequencer over a 2-bit cmd/ack handshake.

Parameters:
- KERNEL_SIZE, 3, kernel width/height; also the column steps per row in the SHIFT phase.
- IMAGE_SIZE, 8, pixels per image row and number of image rows.
- ARRAY_SIZE, 6, PE array width (IMAGE_SIZE-KERNEL_SIZE+1); informational only.
- ADDR_WIDTH, 8, ROM address width.
- BASE_ADDR, 0, ROM address of pixel (0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd  in  2  CMD_IDLE / CMD_PRELOAD_START / CMD_SHIFT_START / CMD_LOAD_START.
- ack  out  2  ACK_IDLE / ACK_PRELOAD_FIN / ACK_SHIFT_FIN / ACK_LOAD_FIN; one-cycle pulse.
- rom_addr  out  ADDR_WIDTH  address to the synchronous ROM (1-cycle read latency).
- rom_data  in  DATA_WIDTH  ROM read data.
- data_out  out  DATA_WIDTH  pixel to the cache; equals rom_data (pass-through).
- current_state  out  3  STATE_INIT..STATE_IDLE, encodings 0..7.
- read_index  out  5  word index within the current phase.
- preload_cycle  out  2  preload row counter, 0..2.
- array_idx  out  2  cache bank select, 0..2.
- image_done  out  1  high once all IMAGE_SIZE rows have been fetched.

Behaviour:
- Reset (rst_n low at a clk edge), all outputs and state registers:
  - current_state=STATE_INIT; read_index=0; preload_cycle=0; array_idx=0.
  - ack=ACK_IDLE; image_done=0; row pointer=0.
  - rom_addr=BASE_ADDR.
  - Reset mid-phase aborts the phase; no ack is issued.
- ROM timing:
  - rom_addr is combinational from next-state/next-index logic.
  - rom_data in the cycle where (current_state, read_index)=(PRELOAD or LOAD, k) holds pixel (row_ptr, k).
  - rom_addr = BASE_ADDR + row_ptr*IMAGE_SIZE + k, truncated to ADDR_WIDTH.
- Command acceptance:
  - cmd is sampled only in INIT and IDLE; it is ignored in every other state.
  - INIT accepts only PRELOAD_START.
- INIT:
  - Stays in INIT until PRELOAD_START, then goes to PRELOAD with read_index=0, preload_cycle=0, row_ptr=0, image_done=0.
- IDLE:
  - PRELOAD_START -> INIT for exactly one cycle (the cache clears), then PRELOAD.
  - SHIFT_START -> ROW_0.
  - LOAD_START -> LOAD, but only if row_ptr<IMAGE_SIZE; otherwise stay in IDLE and pulse ACK_LOAD_FIN next cycle with no fetch.
- PRELOAD (three image rows):
  - preload_cycle 0 and 1: read_index runs 0..8. Index 8 is the shift slot: no fetch, and row_ptr increments.
  - preload_cycle 2: read_index runs 0..7 only; the phase never reaches index 8, so the last row stays in bank 2.
  - After index 7 of cycle 2: row_ptr=3, go to IDLE, and ack=ACK_PRELOAD_FIN for one cycle in the first IDLE cycle.
  - Total 26 PRELOAD cycles.
- SHIFT:
  - ROW_0, ROW_1 and ROW_2 each last KERNEL_SIZE cycles, with read_index 0..KERNEL_SIZE-1 and array_idx=0, 1, 2 respectively.
  - Then BIAS for 1 cycle (array_idx=0, read_index=0), then IDLE with ACK_SHIFT_FIN.
  - Total 10 cycles.
- LOAD:
  - read_index runs 0..7 (8 cycles) and fetches row row_ptr.
  - At exit: row_ptr increments, go to IDLE with ACK_LOAD_FIN.
  - image_done is set in the same cycle row_ptr reaches IMAGE_SIZE.
- Outside active phases, read_index returns to 0 on entry to IDLE.
- preload_cycle holds its value outside PRELOAD.
- ack is ACK_IDLE in every cycle except the single pulse cycle.
- A command presented in the same cycle an ack pulses (already in IDLE) is accepted.

Decomposition:
- Shared header conv_layer_define.v, included beside global_define.v, holds:
  - STATE_*, CMD_*, ACK_* encodings;
  - FLOAT32_ONE;
  - DATA_WIDTH (remains in global_define.v).
- The cache and this block both use that header.
- One natural sub-module: conv_layer_input_addr_gen, holding row_ptr and the rom_addr computation with increment/clear controls.

Test Plan:
- Reset then PRELOAD_START, ROM[a]=a:
  - 26 PRELOAD cycles; rom_data at (cycle 2, index 7) = 23; ACK_PRELOAD_FIN pulses once.
  - Checked against the cache model, banks hold rows 0/1/2.
- SHIFT_START in IDLE:
  - array_idx sequence 0,0,0,1,1,1,2,2,2,0 with states ROW_0×3, ROW_1×3, ROW_2×3, BIAS.
  - ACK_SHIFT_FIN on the 11th cycle.
- Five LOAD_START commands after preload:
  - Addresses 24..63 are fetched; image_done rises with the fifth ACK_LOAD_FIN.
  - A sixth LOAD_START gives ACK_LOAD_FIN after 1 cycle with no state change.
- SHIFT_START held during PRELOAD:
  - Ignored; the PRELOAD sequence is unchanged.
- rst_n low in the middle of LOAD (read_index=4):
  - The next cycle shows all reset values and no ack.
- PRELOAD_START from IDLE with image_done=1:
  - One INIT cycle, then row_ptr=0, image_done=0, rom_addr=BASE_ADDR.
